// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: a fetch port and a data port share one memory port,
// with fixed data priority and a single transaction in flight at a time.
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef WORD_W
`define WORD_W 32
`endif

module mem_arbiter #(
    parameter int ADDR_W = `ADDR_W,
    parameter int WORD_W = `WORD_W
) (
    input  logic              clk,
    input  logic              clr,
    // fetch requester
    input  logic              i_if_req_valid,
    input  logic [ADDR_W-1:0] i_if_req_addr,
    output logic              o_if_req_ready,
    output logic              o_if_rsp_valid,
    output logic [WORD_W-1:0] o_if_rsp_data,
    // data requester
    input  logic              i_d_req_valid,
    input  logic [ADDR_W-1:0] i_d_req_addr,
    input  logic [WORD_W-1:0] i_d_req_wr_data,
    input  logic              i_d_req_wr_en,
    input  logic [1:0]        i_d_req_count,
    output logic              o_d_req_ready,
    output logic              o_d_rsp_valid,
    output logic [WORD_W-1:0] o_d_rsp_data,
    // memory side
    output logic              o_mem_valid,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [WORD_W-1:0] o_mem_wr_data,
    output logic              o_mem_wr_en,
    output logic [1:0]        o_mem_count,
    input  logic              i_mem_ready,
    input  logic              i_mem_rsp_valid,
    input  logic [WORD_W-1:0] i_mem_rsp_data,
    output logic              o_stall
);

    // MEM_COUNT encoding: 0 = byte, 1 = half word, 2 = word.
    localparam logic [1:0] MEM_COUNT_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic              owner_d;
    logic              d_pending;
    logic [ADDR_W-1:0] lat_addr;
    logic [WORD_W-1:0] lat_wr_data;
    logic              lat_wr_en;
    logic [1:0]        lat_count;

    logic grant_d;
    logic grant_if;
    logic rsp_done;

    assign grant_d  = (state == IDLE) && i_d_req_valid;
    assign grant_if = (state == IDLE) && !i_d_req_valid && i_if_req_valid;
    assign rsp_done = (state == RSP) && i_mem_rsp_valid;

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_d || grant_if) state_next = REQ;
            REQ:     if (i_mem_ready)         state_next = RSP;
            RSP:     if (i_mem_rsp_valid)     state_next = IDLE;
            default:                          state_next = IDLE;
        endcase
    end

    always_comb begin
        o_if_req_ready = grant_if;
        o_d_req_ready  = grant_d;
        o_mem_valid    = (state == REQ);
        o_stall        = (i_d_req_valid && !o_d_req_ready) || d_pending;
    end

    assign o_mem_addr    = lat_addr;
    assign o_mem_wr_data = lat_wr_data;
    assign o_mem_wr_en   = lat_wr_en;
    assign o_mem_count   = lat_count;

    // Request latch, ownership and response capture; the rsp_valid pulses are
    // one-cycle strobes while the rsp_data registers hold until the next response.
    always_ff @(posedge clk) begin
        if (clr) begin
            owner_d        <= 1'b0;
            d_pending      <= 1'b0;
            lat_addr       <= '0;
            lat_wr_data    <= '0;
            lat_wr_en      <= 1'b0;
            lat_count      <= 2'd0;
            o_if_rsp_valid <= 1'b0;
            o_d_rsp_valid  <= 1'b0;
            o_if_rsp_data  <= '0;
            o_d_rsp_data   <= '0;
        end else begin
            o_if_rsp_valid <= 1'b0;
            o_d_rsp_valid  <= 1'b0;
            if (rsp_done) begin
                if (owner_d) begin
                    o_d_rsp_valid <= 1'b1;
                    o_d_rsp_data  <= i_mem_rsp_data;
                    d_pending     <= 1'b0;
                end else begin
                    o_if_rsp_valid <= 1'b1;
                    o_if_rsp_data  <= i_mem_rsp_data;
                end
            end
            if (grant_d) begin
                owner_d     <= 1'b1;
                d_pending   <= 1'b1;
                lat_addr    <= i_d_req_addr;
                lat_wr_data <= i_d_req_wr_data;
                lat_wr_en   <= i_d_req_wr_en;
                lat_count   <= i_d_req_count;
            end else if (grant_if) begin
                owner_d     <= 1'b0;
                lat_addr    <= i_if_req_addr;
                lat_wr_data <= '0;
                lat_wr_en   <= 1'b0;
                lat_count   <= MEM_COUNT_WORD;
            end
        end
    end

endmodule
